// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side load/store sequencer for a word-wide, big-endian RAM.
// Checks alignment, drives a mov/moc handshake with byte-lane enables, and
// sign/zero-extends sub-word load data. A bounded wait on moc aborts with err.
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        signed_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mov,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  byte_en,
  input  logic        moc,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RELEASE} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          mov_q, mov_d, mem_rw_q, mem_rw_d;
  logic [31:0]   rdata_q, rdata_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]    byte_en_q, byte_en_d;
  logic [1:0]    size_q, size_d, off_q, off_d;
  logic          sgn_q, sgn_d, to_q, to_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          misaligned;
  logic [3:0]    lanes;
  logic [31:0]   wdata_rep, load_ext;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  // Request decode: alignment check, big-endian lane mask, store-data replication.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    misaligned = 1'b0;
    lanes      = 4'b1111;
    wdata_rep  = wdata;
    case (size)
      2'b00: begin
        lanes     = 4'b1000 >> addr[1:0];
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned = addr[0];
        lanes      = addr[1] ? 4'b0011 : 4'b1100;
        wdata_rep  = {2{wdata[15:0]}};
      end
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Load extraction: pick the addressed lane(s) of the RAM word and extend.
  always_comb begin
    ld_byte  = mem_rdata[{~off_q, 3'b000} +: 8];
    ld_half  = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    load_ext = mem_rdata;
    case (size_q)
      2'b00:   load_ext = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{sgn_q & ld_half[15]}}, ld_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/ACCESS/RELEASE sequence.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mov_d       = mov_q;
    mem_rw_d    = mem_rw_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    byte_en_d   = byte_en_q;
    size_d      = size_q;
    off_d       = off_q;
    sgn_d       = sgn_q;
    to_d        = to_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (misaligned) begin
            // Rejected requests complete immediately and never touch the RAM.
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d     = S_ACCESS;
            busy_d      = 1'b1;
            mov_d       = 1'b1;
            mem_rw_d    = rw;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = wdata_rep;
            byte_en_d   = lanes;
            size_d      = size;
            off_d       = addr[1:0];
            sgn_d       = signed_ld;
            to_d        = 1'b0;
            cnt_d       = '0;
          end
        end
      end
      S_ACCESS: begin
        if (moc) begin
          if (mem_rw_q) rdata_d = load_ext;
          mov_d   = 1'b0;
          state_d = S_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          mov_d   = 1'b0;
          to_d    = 1'b1;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        // Wait for the RAM to withdraw moc so the next access starts clean.
        if (!moc) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = to_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mov_q       <= 1'b0;
      mem_rw_q    <= 1'b1;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      byte_en_q   <= '0;
      size_q      <= '0;
      off_q       <= '0;
      sgn_q       <= 1'b0;
      to_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mov_q       <= mov_d;
      mem_rw_q    <= mem_rw_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      byte_en_q   <= byte_en_d;
      size_q      <= size_d;
      off_q       <= off_d;
      sgn_q       <= sgn_d;
      to_q        <= to_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mov       = mov_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign byte_en   = byte_en_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum ACCESS-state cycles to wait for moc before aborting.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  1  CPU memory-op request, sampled only in IDLE.
REQ-005 SHALL have port rw  input  1  1 = load (read), 0 = store (write).
REQ-006 SHALL have port size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 SHALL have port signed_ld  input  1  1 = sign-extend, 0 = zero-extend sub-word loads.
REQ-008 SHALL have port addr  input  32  byte address (ALU result).
REQ-009 SHALL have port wdata  input  32  store data (register B operand).
REQ-010 SHALL have port busy  output  1  stall to CPU; high whenever state != IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  one-cycle error pulse, coincident with done.
REQ-013 SHALL have port rdata  output  32  extended load result, held until next load completes.
REQ-014 SHALL have port mov  output  1  memory-operation-valid strobe to RAM.
REQ-015 SHALL have port mem_rw  output  1  RW to RAM, same encoding as rw.
REQ-016 SHALL have port mem_addr  output  32  word address to RAM ({addr[31:2],2'b00}).
REQ-017 SHALL have port mem_wdata  output  32  lane-replicated store data.
REQ-018 SHALL have port byte_en  output  4  byte-lane enables; bit 3 = bits 31:24.
REQ-019 SHALL have port moc  input  1  memory-operation-complete from RAM.
REQ-020 SHALL have port mem_rdata  input  32  read word from RAM.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS, RELEASE; all outputs registered.
REQ-022 IDLE: req=1 with legal, aligned request SHALL latch rw/size/signed_ld/addr/wdata and enter ACCESS next cycle with mov=1.
REQ-023 Misalignment = size 01 with addr[0]=1, size 10 with addr[1:0]!=0, or size 11; SHALL pulse done=1, err=1 next cycle, stay IDLE, never assert mov.
REQ-024 Memory is big-endian: byte offset 0 -> lane 3; halfword offset 0 -> lanes 3:2, offset 2 -> lanes 1:0; word -> 4'b1111.
REQ-025 Store: mem_wdata SHALL be {4{wdata[7:0]}} (byte), {2{wdata[15:0]}} (half), wdata (word); byte_en per REQ-024; loads drive byte_en of the accessed lanes.
REQ-026 ACCESS: mov, mem_rw, mem_addr, mem_wdata, byte_en SHALL remain stable until exit.
REQ-027 ACCESS with moc=1 sampled SHALL capture mem_rdata (loads), drop mov, enter RELEASE.
REQ-028 Load result: selected lane(s) right-justified, upper bits = sign bit if signed_ld else 0; rdata updated on load completion only.
REQ-029 Timeout counter SHALL clear on ACCESS entry, increment each ACCESS cycle without moc; at TIMEOUT cycles SHALL drop mov, enter RELEASE, flag error; rdata unchanged.
REQ-030 RELEASE: SHALL wait for moc=0, then return to IDLE and pulse done=1 (err=1 if timed out) in that same cycle.
REQ-031 busy SHALL be 0 in IDLE, including the done cycle; req while busy=1 SHALL be ignored.
REQ-032 req held high after done SHALL start a new access (back-to-back), done-to-next-mov gap one cycle.
REQ-033 Nominal latency: req edge -> mov next cycle; moc at cycle N -> done at N+2 if moc drops one cycle after mov.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, mov=0, busy=0, done=0, err=0, rdata=0, mem_rw=1, mem_addr=0, mem_wdata=0, byte_en=0, timeout count 0.
REQ-035 reset asserted mid-ACCESS or RELEASE SHALL abort the transaction with no done pulse; first req after reset release is honoured normally.

Verification
REQ-036 Word load addr=0x100, mem_rdata=0xDEADBEEF, moc after 3 cycles -> mem_addr=0x100, byte_en=1111, rdata=0xDEADBEEF, single done, err=0.
REQ-037 Signed byte load addr=0x103, mem_rdata=0x123456F0 -> byte_en=0001, rdata=0xFFFFFFF0; same with signed_ld=0 -> 0x000000F0.
REQ-038 Halfword store addr=0x202, wdata=0xAAAA1234 -> mem_addr=0x200, byte_en=0011, mem_wdata=0x12341234, mem_rw=0.
REQ-039 Word load addr=0x101 -> done=1, err=1 next cycle, mov never asserted, busy stays 0.
REQ-040 moc held 0 -> mov drops after 15 ACCESS cycles, done=1 err=1 one cycle later, rdata unchanged.
REQ-041 reset pulled low while mov=1 -> mov, busy 0 immediately, no done; subsequent word load completes normally.
